// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module  : icache_direct_mapped
// Brief   : Direct-mapped, one-word-per-line read-only instruction cache with
//           full-address tags and a single outstanding refill.
// Revision: 1.0 - initial release
// ============================================================================
module icache_direct_mapped #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ifetch,
    input  logic [31:0] instraddress,
    input  logic        iready,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        miss,
    output logic [31:0] fetchaddr
);

    localparam int c_LINES = 1 << INDEX_BITS;

    typedef enum logic [0:0] {
        LOOKUP   = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_valid [c_LINES];
    logic [31:0]             r_tag   [c_LINES];
    logic [31:0]             r_data  [c_LINES];

    logic [INDEX_BITS-1:0]   w_index;
    logic [INDEX_BITS-1:0]   w_fill_index;
    logic                    w_hit;
    logic                    w_refill;

    assign w_index      = instraddress[INDEX_BITS+1:2];
    assign w_fill_index = fetchaddr[INDEX_BITS+1:2];
    // Tag holds the full address so even byte-offset bits must match.
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == instraddress);
    assign w_refill     = reset && (r_state == WAIT_MEM) && iready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= LOOKUP;
            hit         <= 1'b0;
            miss        <= 1'b0;
            instruction <= 32'h0;
            fetchaddr   <= 32'h0;
            for (int i = 0; i < c_LINES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            case (r_state)
                LOOKUP: begin
                    if (w_hit) begin
                        hit         <= 1'b1;
                        miss        <= 1'b0;
                        instruction <= r_data[w_index];
                    end else begin
                        hit       <= 1'b0;
                        miss      <= 1'b1;
                        fetchaddr <= instraddress;
                        r_state   <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (iready) begin
                        r_valid[w_fill_index] <= 1'b1;
                        instruction           <= ifetch;
                        hit                   <= 1'b0;
                        miss                  <= 1'b0;
                        r_state               <= LOOKUP;
                    end
                end
                default: r_state <= LOOKUP;
            endcase
        end
    end

    // Payload arrays are not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_refill) begin
            r_tag[w_fill_index]  <= fetchaddr;
            r_data[w_fill_index] <= ifetch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_direct_mapped
// Brief   : Directed plus randomized checks of icache_direct_mapped against a
//           behavioural cache model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache_direct_mapped;

    localparam int c_LINES = 16;

    logic        clk;
    logic        reset;
    logic [31:0] ifetch;
    logic [31:0] instraddress;
    logic        iready;
    logic [31:0] instruction;
    logic        hit;
    logic        miss;
    logic [31:0] fetchaddr;

    icache_direct_mapped #(.INDEX_BITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ifetch       (ifetch),
        .instraddress (instraddress),
        .iready       (iready),
        .instruction  (instruction),
        .hit          (hit),
        .miss         (miss),
        .fetchaddr    (fetchaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a table of lines plus the address of the pending miss.
    bit          m_valid [c_LINES];
    bit [31:0]   m_addr  [c_LINES];
    bit [31:0]   m_data  [c_LINES];
    bit          m_pending;
    bit          e_hit;
    bit          e_miss;
    bit [31:0]   e_instr;
    bit [31:0]   e_faddr;

    int          seen_hits;
    int          seen_misses;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic rdy, input logic [31:0] d, input logic rn);
        int idx;
        instraddress = a;
        iready       = rdy;
        ifetch       = d;
        reset        = rn;
        if (!rn) begin
            for (int i = 0; i < c_LINES; i++) m_valid[i] = 0;
            m_pending = 0;
            e_hit = 0; e_miss = 0; e_instr = 0; e_faddr = 0;
        end else if (!m_pending) begin
            idx = int'((a / 4) % c_LINES);
            if (m_valid[idx] && m_addr[idx] == a) begin
                e_hit = 1; e_miss = 0; e_instr = m_data[idx];
                seen_hits++;
            end else begin
                e_hit = 0; e_miss = 1; e_faddr = a; m_pending = 1;
                seen_misses++;
            end
        end else if (rdy) begin
            idx = int'((e_faddr / 4) % c_LINES);
            m_valid[idx] = 1; m_addr[idx] = e_faddr; m_data[idx] = d;
            e_instr = d; e_hit = 0; e_miss = 0; m_pending = 0;
        end
        @(posedge clk);
        #1;
        check_eq("hit",         {31'b0, hit},  {31'b0, e_hit});
        check_eq("miss",        {31'b0, miss}, {31'b0, e_miss});
        check_eq("instruction", instruction,   e_instr);
        check_eq("fetchaddr",   fetchaddr,     e_faddr);
    endtask

    // One lookup; if it missed, refill on the next cycle with the given word.
    task automatic access(input logic [31:0] a, input logic [31:0] d);
        step(a, 1'b0, 32'h0, 1'b1);
        if (m_pending) step(a, 1'b1, d, 1'b1);
    endtask

    initial begin
        int hits0, miss0;
        logic [31:0] a;
        reset = 1'b0; iready = 1'b0; ifetch = 32'h0; instraddress = 32'h0;
        m_pending = 0; seen_hits = 0; seen_misses = 0;
        step(32'h0, 1'b0, 32'h0, 1'b0);
        step(32'h0, 1'b0, 32'h0, 1'b0);

        // Basic miss/refill, then hit
        step(32'h08, 1'b0, 32'h0, 1'b1);
        check_eq("first_miss_flag", {31'b0, miss}, 32'd1);
        check_eq("first_miss_addr", fetchaddr, 32'h08);
        step(32'h08, 1'b1, 32'h10000000, 1'b1);
        check_eq("refill_word", instruction, 32'h10000000);
        step(32'h08, 1'b0, 32'h0, 1'b1);
        check_eq("rehit", {31'b0, hit}, 32'd1);

        // Byte-offset conflict and eviction
        access(32'h09, 32'h10000002);
        step(32'h09, 1'b0, 32'h0, 1'b1);
        check_eq("hit_09", instruction, 32'h10000002);
        step(32'h08, 1'b0, 32'h0, 1'b1);
        check_eq("evicted_08", {31'b0, miss}, 32'd1);
        step(32'h08, 1'b1, 32'h10000000, 1'b1);

        // Seven-access sequence from a clean cache
        step(32'h0, 1'b0, 32'h0, 1'b0);
        hits0 = seen_hits; miss0 = seen_misses;
        begin
            logic [31:0] seq [7] = '{32'h08, 32'h08, 32'h09, 32'h09, 32'h0C, 32'h0E, 32'h0E};
            int dut_hits = 0;
            for (int i = 0; i < 7; i++) begin
                step(seq[i], 1'b0, 32'h0, 1'b1);
                if (hit) dut_hits++;
                if (m_pending) step(seq[i], 1'b1, 32'h10000000 + i, 1'b1);
            end
            check_eq("seq_hits", dut_hits, 32'd3);
            check_eq("seq_model_hits", seen_hits - hits0, 32'd3);
            check_eq("seq_model_misses", seen_misses - miss0, 32'd4);
        end

        // Outstanding miss ignores address changes while waiting
        step(32'h20, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step($urandom, 1'b0, $urandom, 1'b1);
        check_eq("hold_faddr", fetchaddr, 32'h20);
        step(32'h44, 1'b1, 32'hABCD1234, 1'b1);
        step(32'h20, 1'b0, 32'h0, 1'b1);
        check_eq("held_refill_hit", {31'b0, hit}, 32'd1);
        check_eq("held_refill_word", instruction, 32'hABCD1234);

        // Reset in WAIT_MEM with iready aborts the refill
        step(32'h44, 1'b0, 32'h0, 1'b1);
        step(32'h44, 1'b1, 32'h55555555, 1'b0);
        check_eq("abort_faddr", fetchaddr, 32'h0);
        step(32'h44, 1'b0, 32'h0, 1'b1);
        check_eq("abort_no_line", {31'b0, miss}, 32'd1);
        step(32'h44, 1'b1, 32'h66666666, 1'b1);

        // Randomized traffic over a small address pool to force conflicts
        for (int i = 0; i < 3000; i++) begin
            a = {25'b0, 7'($urandom_range(0, 127))};
            step(a, ($urandom_range(0, 99) < 35), $urandom, ($urandom_range(0, 199) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
